i2s_master_sequencer: RTL and testbench

//  Clock master and frame scheduler for the I2S transceiver. Divides clk into BCLK/LRCLK,

---
 rtl/i2s_master_sequencer_if.sv | 24 ++
 rtl/i2s_master_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_i2s_master_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_master_sequencer_if.sv
// Sample-pair handshake between the I2S frame scheduler and the upstream synth/mixer.
// The sequencer is the master: it raises sample_req and the source answers with a valid pair.
interface i2s_master_sequencer_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    sample_req;
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] left_smp;
  logic [SAMPLE_WIDTH-1:0] right_smp;

  modport master (
    output sample_req,
    input  sample_valid,
    input  left_smp,
    input  right_smp
  );

  modport slave (
    input  sample_req,
    output sample_valid,
    output left_smp,
    output right_smp
  );
endinterface

// File: rtl/i2s_master_sequencer.sv
// I2S clock master and frame scheduler: derives BCLK/LRCLK from clk, fetches one stereo
// pair per frame and presents it to the transceiver from the start of the right slot.
module i2s_master_sequencer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_DIV     = 8,
  parameter int BITS_PER_CH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    frame_start,
  i2s_master_sequencer_if.master  smp,
  output logic [SAMPLE_WIDTH-1:0] left_in,
  output logic [SAMPLE_WIDTH-1:0] right_in,
  output logic                    underrun,
  input  logic                    underrun_clr
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * BITS_PER_CH);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(2 * BITS_PER_CH - 1);
  localparam logic [BIT_W-1:0] BIT_DEADLINE = BIT_W'(BITS_PER_CH - 1);
  localparam logic [BIT_W-1:0] BIT_RIGHT    = BIT_W'(BITS_PER_CH);
  localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GOT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                    bclk_reg, bclk_next;
  logic                    lrclk_reg, lrclk_next;
  logic                    frame_start_reg, frame_start_next;
  logic                    req_reg, req_next;
  logic                    underrun_reg, underrun_next;
  logic [SAMPLE_WIDTH-1:0] pend_left_reg, pend_left_next;
  logic [SAMPLE_WIDTH-1:0] pend_right_reg, pend_right_next;
  logic [SAMPLE_WIDTH-1:0] left_reg, left_next;
  logic [SAMPLE_WIDTH-1:0] right_reg, right_next;

  logic tick;
  logic deadline;
  logic boundary;
  logic xfer;
  logic underrun_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      div_cnt_reg     <= '0;
      bit_cnt_reg     <= '0;
      bclk_reg        <= 1'b0;
      lrclk_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      req_reg         <= 1'b0;
      underrun_reg    <= 1'b0;
      pend_left_reg   <= '0;
      pend_right_reg  <= '0;
      left_reg        <= '0;
      right_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      div_cnt_reg     <= div_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      bclk_reg        <= bclk_next;
      lrclk_reg       <= lrclk_next;
      frame_start_reg <= frame_start_next;
      req_reg         <= req_next;
      underrun_reg    <= underrun_next;
      pend_left_reg   <= pend_left_next;
      pend_right_reg  <= pend_right_next;
      left_reg        <= left_next;
      right_reg       <= right_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    div_cnt_next     = div_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    frame_start_next = 1'b0;
    req_next         = req_reg;
    pend_left_next   = pend_left_reg;
    pend_right_next  = pend_right_reg;
    left_next        = left_reg;
    right_next       = right_reg;
    underrun_set     = 1'b0;

    tick     = (div_cnt_reg == DIV_LAST);
    deadline = tick && (bit_cnt_reg == BIT_DEADLINE);
    boundary = tick && (bit_cnt_reg == BIT_LAST);
    xfer     = req_reg && smp.sample_valid;

    if (state_reg != IDLE) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + DIV_ONE;
      if (tick) begin
        bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_ONE;
      end
    end

    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        bit_cnt_next = '0;
        req_next     = 1'b0;
        if (enable) begin
          state_next       = WAIT;
          frame_start_next = 1'b1;
          req_next         = 1'b1;
        end
      end
      WAIT: begin
        // A pair arriving on the deadline tick goes straight to the outputs.
        if (xfer && deadline) begin
          left_next  = smp.left_smp;
          right_next = smp.right_smp;
          req_next   = 1'b0;
          state_next = DONE;
        end else if (xfer) begin
          pend_left_next  = smp.left_smp;
          pend_right_next = smp.right_smp;
          req_next        = 1'b0;
          state_next      = GOT;
        end else if (deadline) begin
          underrun_set = 1'b1;
          req_next     = 1'b0;
          state_next   = DONE;
        end
      end
      GOT: begin
        if (deadline) begin
          left_next  = pend_left_reg;
          right_next = pend_right_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        if (boundary) begin
          if (enable) begin
            state_next       = WAIT;
            frame_start_next = 1'b1;
            req_next         = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    underrun_next = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_reg);

    // Clock outputs are registered from the next counter values so they track the counters exactly.
    bclk_next  = (div_cnt_next >= DIV_HALF);
    lrclk_next = (bit_cnt_next >= BIT_RIGHT);
  end

  assign bclk           = bclk_reg;
  assign lrclk          = lrclk_reg;
  assign frame_start    = frame_start_reg;
  assign smp.sample_req = req_reg;
  assign left_in        = left_reg;
  assign right_in       = right_reg;
  assign underrun       = underrun_reg;

endmodule

// File: tb/tb_i2s_master_sequencer.sv
// Bench for i2s_master_sequencer: directed frame scenarios followed by randomized traffic,
// all outputs compared every cycle against a frame-phase reference model.
module tb_i2s_master_sequencer;
  localparam int SW          = 16;
  localparam int DIV         = 4;
  localparam int BPC         = 16;
  localparam int FRAME       = 2 * DIV * BPC;
  localparam int DEADLINE_PH = BPC * DIV - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          underrun_clr;
  logic          bclk, lrclk, frame_start, underrun;
  logic [SW-1:0] left_in, right_in;

  i2s_master_sequencer_if #(.SAMPLE_WIDTH(SW)) smp_if ();

  i2s_master_sequencer #(
    .SAMPLE_WIDTH(SW),
    .BCLK_DIV    (DIV),
    .BITS_PER_CH (BPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .frame_start (frame_start),
    .smp         (smp_if),
    .left_in     (left_in),
    .right_in    (right_in),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: m_ph is the clk index within the frame (0 = frame_start cycle).
  bit            m_run = 0;
  int            m_ph  = 0;
  bit            m_req = 0, m_fs = 0, m_und = 0, m_got = 0;
  logic [SW-1:0] m_l = '0, m_r = '0, m_pl = '0, m_pr = '0;

  // Responder plan: valid from phase resp_delay on while requested; -1 = silent.
  int            resp_delay = -1;
  logic [SW-1:0] resp_l = '0, resp_r = '0;
  bit            junk_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_resp();
    if (m_req && resp_delay >= 0 && m_ph >= resp_delay) begin
      smp_if.sample_valid = 1'b1;
      smp_if.left_smp     = resp_l;
      smp_if.right_smp    = resp_r;
    end else begin
      smp_if.sample_valid = (junk_en && !m_req) ? 1'($urandom_range(0, 1)) : 1'b0;
      smp_if.left_smp     = SW'($urandom);
      smp_if.right_smp    = SW'($urandom);
    end
  endtask

  task automatic model_step();
    bit xfer;
    bit set_u;
    if (reset) begin
      m_run = 0; m_ph = 0; m_req = 0; m_fs = 0; m_und = 0; m_got = 0;
      m_l = '0; m_r = '0;
    end else begin
      xfer  = m_req && smp_if.sample_valid;
      set_u = 0;
      m_fs  = 0;
      if (xfer) $display("xfer t=%0t ph=%0d L=%h R=%h", $time, m_ph, smp_if.left_smp, smp_if.right_smp);
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_ph = 0; m_req = 1; m_fs = 1; m_got = 0;
        end
      end else begin
        if (m_ph == DEADLINE_PH) begin
          if (xfer) begin
            m_l = smp_if.left_smp; m_r = smp_if.right_smp;
          end else if (m_got) begin
            m_l = m_pl; m_r = m_pr;
          end else begin
            set_u = 1;
            $display("miss t=%0t deadline without transfer", $time);
          end
          m_req = 0; m_got = 0;
        end else if (xfer) begin
          m_pl = smp_if.left_smp; m_pr = smp_if.right_smp; m_got = 1; m_req = 0;
        end
        if (m_ph == FRAME - 1) begin
          m_ph = 0;
          if (enable) begin
            m_req = 1; m_fs = 1;
          end else begin
            m_run = 0;
          end
        end else begin
          m_ph++;
        end
      end
      m_und = set_u ? 1'b1 : (underrun_clr ? 1'b0 : m_und);
    end
  endtask

  task automatic check_all();
    chk("bclk",        bclk,            m_run && ((m_ph % DIV) >= DIV / 2));
    chk("lrclk",       lrclk,           m_run && (m_ph >= FRAME / 2));
    chk("frame_start", frame_start,     m_fs);
    chk("sample_req",  smp_if.sample_req, m_req);
    chk("left_in",     left_in,         m_l);
    chk("right_in",    right_in,        m_r);
    chk("underrun",    underrun,        m_und);
  endtask

  // One clk: drive the responder, advance the model over the coming edge, check on the falling edge.
  task automatic cyc();
    drive_resp();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int target);
    run_n((target - m_ph + FRAME) % FRAME);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; underrun_clr = 1'b0;
    smp_if.sample_valid = 1'b0; smp_if.left_smp = '0; smp_if.right_smp = '0;

    // 1: reset and idle
    run_n(5);
    chk("rst_left", left_in, 16'h0000);
    chk("rst_req", smp_if.sample_req, 1'b0);
    reset = 1'b0;
    run_n(10);
    chk("idle_bclk", bclk, 1'b0);
    chk("idle_lrclk", lrclk, 1'b0);

    // 2: normal frames, responder answers 3 clk after req
    resp_delay = 3; resp_l = 16'h1234; resp_r = 16'hABCD;
    enable = 1'b1;
    run_n(1);
    chk("fs_first", frame_start, 1'b1);
    chk("req_first", smp_if.sample_req, 1'b1);
    run_to(63);
    chk("left_before_rise", left_in, 16'h0000);
    run_to(64);
    chk("lrclk_rise", lrclk, 1'b1);
    chk("left_1234", left_in, 16'h1234);
    chk("right_abcd", right_in, 16'hABCD);
    run_to(0);
    chk("fs_frame2", frame_start, 1'b1);

    // 3: silent frame -> underrun, outputs held, then recovery and clear
    resp_delay = -1;
    run_to(64);
    chk("und_set", underrun, 1'b1);
    chk("und_hold_left", left_in, 16'h1234);
    chk("und_req_low", smp_if.sample_req, 1'b0);
    run_to(0);
    resp_delay = 5; resp_l = 16'h5555; resp_r = 16'hAAAA;
    run_to(64);
    chk("recover_left", left_in, 16'h5555);
    underrun_clr = 1'b1;
    run_n(1);
    underrun_clr = 1'b0;
    chk("und_cleared", underrun, 1'b0);

    // 4: transfer on the deadline tick itself; then clear coinciding with a miss
    run_to(0);
    resp_delay = DEADLINE_PH; resp_l = 16'h0F0F; resp_r = 16'hF0F0;
    run_to(64);
    chk("late_left", left_in, 16'h0F0F);
    chk("late_no_und", underrun, 1'b0);
    run_to(0);
    resp_delay = -1;
    run_to(DEADLINE_PH);
    underrun_clr = 1'b1;
    run_n(1);
    underrun_clr = 1'b0;
    chk("set_wins", underrun, 1'b1);

    // 5: enable dropped at bit_cnt 20, then re-enable; then drop/restore within one frame
    run_to(0);
    resp_delay = 2; resp_l = SW'($urandom); resp_r = SW'($urandom);
    run_to(80);
    enable = 1'b0;
    run_n(FRAME - 80);
    chk("stop_bclk", bclk, 1'b0);
    chk("stop_lrclk", lrclk, 1'b0);
    chk("stop_req", smp_if.sample_req, 1'b0);
    run_n(20);
    enable = 1'b1;
    run_n(1);
    chk("restart_fs", frame_start, 1'b1);
    run_to(80);
    enable = 1'b0;
    run_to(100);
    enable = 1'b1;
    run_to(0);
    chk("nogap_fs", frame_start, 1'b1);

    // 6: reset while waiting with req high
    resp_delay = 40;
    run_to(10);
    chk("pre_rst_req", smp_if.sample_req, 1'b1);
    reset = 1'b1;
    run_n(1);
    reset = 1'b0;
    chk("rst_mid_req", smp_if.sample_req, 1'b0);
    chk("rst_mid_left", left_in, 16'h0000);
    chk("rst_mid_right", right_in, 16'h0000);
    chk("rst_mid_und", underrun, 1'b0);

    // Randomized traffic: delays, misses, stray valids, clears and enable toggles
    for (int c = 0; c < 2500; c++) begin
      if (m_run && m_ph == 0) begin
        resp_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 70));
        resp_l     = SW'($urandom);
        resp_r     = SW'($urandom);
        junk_en    = 1'($urandom_range(0, 1));
      end
      underrun_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      run_n(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
